// File: rtl/mem_if_pkg.sv
// Shared types and default widths for the processor-side data-memory interface.
package mem_if_pkg;

  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_ADDR_W = 10;
  localparam int unsigned MEM_TAG_W  = 4;
  localparam int unsigned CORE_AW    = 32;

  typedef struct packed {
    logic                  we;
    logic [CORE_AW-1:0]    addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_TAG_W-1:0]  tag;
  } mem_req_t;

  typedef enum logic [1:0] {
    MREQ_IDLE,
    MREQ_REQ,
    MREQ_WAIT,
    MREQ_RESP
  } mreq_state_e;

  // Byte address to memory word address.
  function automatic logic [MEM_ADDR_W-1:0] word_addr(input logic [CORE_AW-1:0] a);
    return a[MEM_ADDR_W+1:2];
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO; pushes when full and pops when empty are dropped.
module req_fifo
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  mem_req_t                 wdata,
  output mem_req_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  mem_req_t             mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 do_push, do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mem_req_master.sv
// Processor-side initiator: queues tagged load/store requests, issues them one at
// a time to the data memory and returns one tagged response per request.
module mem_req_master
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_W  = MEM_DATA_W,
  parameter int unsigned MEM_AW  = MEM_ADDR_W,
  parameter int unsigned TAG_W   = MEM_TAG_W,
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CORE_VALID,
  output logic              CORE_READY,
  input  logic              CORE_WE,
  input  logic [31:0]       CORE_ADDR,
  input  logic [DATA_W-1:0] CORE_WDATA,
  input  logic [TAG_W-1:0]  CORE_TAG,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [TAG_W-1:0]  RSP_TAG,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_WE,
  output logic              RSP_ERR,
  output logic              PROC_REQ,
  input  logic              MEM_RDY,
  output logic [MEM_AW-1:0] ADDR,
  output logic              WWE,
  output logic [DATA_W-1:0] WWDATA,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              VALID
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned FCNT_W = $clog2(QDEPTH) + 1;

  mreq_state_e       state_q, state_d;
  mem_req_t          hold_q, hold_d, push_req, head;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              proc_req_q, proc_req_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              fifo_full, fifo_empty, pop;
  logic [FCNT_W-1:0] fifo_count;
  logic              timed_out;

  always_comb begin
    push_req.we    = CORE_WE;
    push_req.addr  = CORE_ADDR;
    push_req.wdata = MEM_DATA_W'(CORE_WDATA);
    push_req.tag   = MEM_TAG_W'(CORE_TAG);
  end

  req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RSTn),
    .push  (CORE_VALID),
    .pop   (pop),
    .wdata (push_req),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      MREQ_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = head;
          rdata_d = '0;
          err_d   = (head.addr[1:0] != 2'b00);
          state_d = (head.addr[1:0] != 2'b00) ? MREQ_RESP : MREQ_REQ;
        end
      end
      MREQ_REQ: begin
        if (MEM_RDY) begin
          state_d = hold_q.we ? MREQ_RESP : MREQ_WAIT;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = MREQ_RESP;
        end
      end
      MREQ_WAIT: begin
        if (VALID) begin
          rdata_d = RDATA;
          state_d = MREQ_RESP;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = MREQ_RESP;
        end
      end
      MREQ_RESP: begin
        if (RSP_READY) state_d = MREQ_IDLE;
      end
      default: state_d = MREQ_IDLE;
    endcase

    // Counter restarts on entry to each awaiting state.
    if ((state_d != state_q) && (state_d == MREQ_REQ || state_d == MREQ_WAIT)) begin
      cnt_d = '0;
    end else if (state_q == MREQ_REQ || state_q == MREQ_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    proc_req_d  = (state_d == MREQ_REQ);
    rsp_valid_d = (state_d == MREQ_RESP);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= MREQ_IDLE;
      hold_q      <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      proc_req_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      proc_req_q  <= proc_req_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign CORE_READY = !fifo_full;
  assign PROC_REQ   = proc_req_q;
  assign ADDR       = MEM_AW'(word_addr(hold_q.addr));
  assign WWE        = hold_q.we;
  assign WWDATA     = DATA_W'(hold_q.wdata);
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_TAG    = TAG_W'(hold_q.tag);
  assign RSP_DATA   = rdata_q;
  assign RSP_WE     = hold_q.we;
  assign RSP_ERR    = err_q;

  a_full_count: assert property (@(posedge CLK) disable iff (!RSTn)
    fifo_full == (fifo_count == FCNT_W'(QDEPTH)));

endmodule
